// File: rtl/mul4x4_seq_ctrl.sv
// mul4x4_seq_ctrl: sequencer for a 4x4 shift-add multiplier, valid/ready in and out
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   abort              synchronous flush back to IDLE, drops any operation in flight
//   in_valid/in_ready  operand handshake; in_a multiplicand, in_b multiplier (4 bits each)
//   out_valid/out_ready product handshake; out_product 8-bit result
//   busy               high whenever the sequencer is not IDLE
//   step               partial-product index 0..3 while accumulating, 0 otherwise
module mul4x4_seq_ctrl #(
    parameter logic SIGNED      = 1'b1,
    parameter logic BYPASS_ZERO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_product,
    output logic       busy,
    output logic [1:0] step
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic [1:0] step_q, step_d;
    logic [3:0] ma_q, ma_d, mb_q, mb_d;
    logic       neg_q, neg_d;
    logic [7:0] sum_q, sum_d, prod_q, prod_d;
    logic       accept, bypass;
    logic [3:0] abs_a, abs_b, pp;
    logic [4:0] sh, add5;
    logic [7:0] sum_acc;

    always_comb begin
        in_ready = !abort && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
        accept   = in_valid && in_ready;
        abs_a    = (SIGNED && in_a[3]) ? -in_a : in_a;
        abs_b    = (SIGNED && in_b[3]) ? -in_b : in_b;
        bypass   = BYPASS_ZERO && (in_a == 4'd0 || in_b == 4'd0);
        pp       = mb_q[step_q] ? ma_q : 4'd0;
        // Window sum[k+4:k]; the 4-bit field absorbs pp and the carry lands in bit k+4 only
        sh       = 5'(sum_q >> step_q);
        add5     = {1'b0, sh[3:0]} + {1'b0, pp};
        sum_acc  = (sum_q & ~(8'h1F << step_q)) | ({3'b000, sh[4] ^ add5[4], add5[3:0]} << step_q);
        state_d  = state_q;
        step_d   = step_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        neg_d    = neg_q;
        sum_d    = sum_q;
        prod_d   = prod_q;
        if (abort) begin
            state_d = S_IDLE;
            step_d  = 2'd0;
        end else if (accept) begin
            ma_d    = abs_a;
            mb_d    = abs_b;
            neg_d   = SIGNED & (in_a[3] ^ in_b[3]);
            sum_d   = 8'd0;
            step_d  = 2'd0;
            state_d = bypass ? S_DONE : S_ACC;
            prod_d  = bypass ? 8'd0 : prod_q;
        end else if (state_q == S_ACC) begin
            sum_d   = sum_acc;
            step_d  = step_q + 2'd1;
            state_d = (step_q == 2'd3) ? S_DONE : S_ACC;
            prod_d  = (step_q == 2'd3) ? (neg_q ? -sum_acc : sum_acc) : prod_q;
        end else if (state_q == S_DONE && out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 2'd0;
            ma_q    <= 4'd0;
            mb_q    <= 4'd0;
            neg_q   <= 1'b0;
            sum_q   <= 8'd0;
            prod_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            sum_q   <= sum_d;
            prod_q  <= prod_d;
        end
    end

    assign out_valid   = (state_q == S_DONE);
    assign out_product = prod_q;
    assign busy        = (state_q != S_IDLE);
    assign step        = step_q;
endmodule
